rx_oversampled_fifo: RTL and testbench

RX_OVERSAMPLED_FIFO -- requirements
Module: rx_oversampled_fifo

---
 rtl/serial_pkg.sv | 52 +++++
 rtl/rx_fifo.sv | 67 ++++++
 rtl/rx_oversampled_fifo.sv | 195 +++++++++++++++++++
 tb/tb_rx_oversampled_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the oversampled serial receiver: parity modes, receiver states
// and the layout of one received-frame FIFO entry.
package serial_pkg;

  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRKWAIT
  } rx_state_e;

  typedef struct packed {
    logic                     brk;
    logic                     pe;
    logic                     fe;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  // Codes 5..7 behave as "no parity".
  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode >= 3'(PAR_EVEN)) && (mode <= 3'(PAR_SPACE));
  endfunction

  // Unused upper data bits are held at zero, so a full-width XOR is correct for any length.
  function automatic logic expected_parity(input logic [2:0]               mode,
                                           input logic [MAX_DATA_BITS-1:0] data);
    logic p;
    p = 1'b0;
    case (mode)
      3'(PAR_EVEN): p = ^data;
      3'(PAR_ODD):  p = ~^data;
      3'(PAR_MARK): p = 1'b1;
      default:      p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through FIFO holding received frames, with a sticky overrun flag
// raised when a push finds no room.
module rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear_overrun,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             overrun_q, overrun_d;
  logic             push_ok, pop_ok;

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    pop_ok    = pop && (level_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok   = push && ((level_q != FULL_LEVEL) || pop_ok);
    wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    overrun_d = (overrun_q && !clear_overrun) || (push && !push_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LEVEL);
  assign level   = level_q;
  assign overrun = overrun_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rx_oversampled_fifo.sv
// Oversampling asynchronous serial receiver with majority-vote bit sampling, parity,
// framing and break detection, feeding a FWFT receive FIFO.
module rx_oversampled_fifo
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   brgen,
  input  logic [1:0]             size,
  input  logic                   stop2,
  input  logic [2:0]             parity,
  input  logic                   in,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   rd_fe,
  output logic                   rd_pe,
  output logic                   rd_brk,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  input  logic                   clear_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_A = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] MID_B = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] MID_C = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);

  logic                     sync1_q, sync2_q, brgen_q;
  rx_state_e                state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               bit_q, bit_d;
  logic [1:0]               samp_q, samp_d;
  logic [MAX_DATA_BITS-1:0] data_q, data_d;
  logic                     fe_q, fe_d, pe_q, pe_d, zero_q, zero_d;
  logic                     line, tick, maj, brk_now, push;
  rx_entry_t                push_entry, head_entry;

  assign line = sync2_q;
  assign tick = brgen && !brgen_q && enable;
  // Third vote comes straight from the line on the tick that decides the bit.
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    data_d     = data_q;
    fe_d       = fe_q;
    pe_d       = pe_q;
    zero_d     = zero_q;
    brk_now    = 1'b0;
    push       = 1'b0;
    push_entry = '0;

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == MID_A) samp_d[0] = line;
      if (cnt_q == MID_B) samp_d[1] = line;

      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!line) begin
            state_d = S_START;
            bit_d   = '0;
            data_d  = '0;
            fe_d    = 1'b0;
            pe_d    = 1'b0;
            zero_d  = 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == MID_C && maj) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (cnt_q == MID_C) begin
            data_d[bit_q] = maj;
            if (maj) zero_d = 1'b0;
          end else if (cnt_q == LAST) begin
            if (bit_q == 3'(size) + 3'd4) begin
              state_d = parity_enabled(parity) ? S_PARITY : S_STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (cnt_q == MID_C) begin
            pe_d = (maj != expected_parity(parity, data_q));
            if (maj) zero_d = 1'b0;
          end else if (cnt_q == LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
          end
        end
        S_STOP: begin
          if (cnt_q == MID_C) begin
            fe_d = fe_q | ~maj;
            if (bit_q == 3'd0) zero_d = zero_q & ~maj;
            if (bit_q == 3'(stop2)) begin
              // Break is decided by the first stop bit; a second one only adds to fe.
              brk_now         = (bit_q == 3'd0) ? (zero_q & ~maj) : zero_q;
              push            = 1'b1;
              push_entry.brk  = brk_now;
              push_entry.fe   = brk_now | fe_q | ~maj;
              push_entry.pe   = brk_now ? 1'b0 : pe_q;
              push_entry.data = brk_now ? '0 : data_q;
              state_d         = brk_now ? S_BRKWAIT : S_IDLE;
              cnt_d           = '0;
            end
          end else if (cnt_q == LAST) begin
            bit_d = bit_q + 3'd1;
          end
        end
        S_BRKWAIT: begin
          cnt_d = '0;
          if (line) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      brgen_q <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      data_q  <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      brgen_q <= brgen;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      zero_q  <= zero_d;
    end
  end

  rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_data     (push_entry),
    .pop           (rd_en),
    .clear_overrun (clear_overrun),
    .head          (head_entry),
    .empty         (empty),
    .full          (full),
    .level         (level),
    .overrun       (overrun)
  );

  assign rd_data = head_entry.data;
  assign rd_fe   = head_entry.fe;
  assign rd_pe   = head_entry.pe;
  assign rd_brk  = head_entry.brk;

endmodule

// File: tb/tb_rx_oversampled_fifo.sv
// Directed bench for rx_oversampled_fifo (OVERSAMPLE=16, DEPTH=4): frames are bit-banged
// against a bench-driven oversample tick and the FIFO head is compared with hand values.
module tb_rx_oversampled_fifo;
  import serial_pkg::*;

  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, enable, brgen, stop2, in_line, rd_en, clear_overrun;
  logic [1:0]    size;
  logic [2:0]    parity;
  logic [7:0]    rd_data;
  logic          rd_fe, rd_pe, rd_brk, empty, full, overrun;
  logic [LW-1:0] level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rx_oversampled_fifo #(.OVERSAMPLE(OS), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .brgen         (brgen),
    .size          (size),
    .stop2         (stop2),
    .parity        (parity),
    .in            (in_line),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_fe         (rd_fe),
    .rd_pe         (rd_pe),
    .rd_brk        (rd_brk),
    .empty         (empty),
    .full          (full),
    .level         (level),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  task automatic do_ticks(input int n);
    repeat (n) begin
      @(negedge clk); brgen = 1'b1;
      @(negedge clk); brgen = 1'b0;
    end
  endtask

  task automatic send_bit(input logic v);
    in_line = v;
    do_ticks(OS);
  endtask

  // par_bit < 0 means no parity bit on the wire; two idle bit-times follow the stop bits.
  task automatic send_frame(input logic [7:0] d, input int nbits, input int par_bit, input int nstop);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (par_bit >= 0) send_bit(par_bit[0]);
    for (int i = 0; i < nstop; i++) send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic pop_one();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; brgen = 1'b0; in_line = 1'b0; rd_en = 1'b0;
    clear_overrun = 1'b0; size = 2'd3; stop2 = 1'b0; parity = 3'd0;
    repeat (4) @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if ({rd_data, rd_fe, rd_pe, rd_brk} !== 11'h0) begin errors++; $display("FAIL reset_head: got %h/%b%b%b want 0", rd_data, rd_fe, rd_pe, rd_brk); end
    checks++; if ({dut.sync1_q, dut.sync2_q} !== 2'b11) begin errors++; $display("FAIL reset_sync: got %b want 11", {dut.sync1_q, dut.sync2_q}); end
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    in_line = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    do_ticks(2 * OS);
  endtask

  task automatic test_basic();
    size = 2'd3; parity = 3'd0; stop2 = 1'b0;
    send_frame(8'hA5, 8, -1, 1);
    checks++; if (level !== LW'(1)) begin errors++; $display("FAIL basic_level: got %0d want 1", level); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", rd_data); end
    checks++; if ({rd_fe, rd_pe, rd_brk} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b want 000", {rd_fe, rd_pe, rd_brk}); end
    pop_one();
    checks++; if (empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL basic_pop: empty=%b data=%h want 1/00", empty, rd_data); end
  endtask

  task automatic test_parity();
    // 0x15 has three ones: even expects 1 (send 0 -> error), odd expects 0 (send 0 -> clean).
    size = 2'd0; parity = 3'd1; stop2 = 1'b0;
    send_frame(8'h15, 5, 0, 1);
    checks++; if (rd_data !== 8'h15) begin errors++; $display("FAIL even_data: got %h want 15", rd_data); end
    checks++; if ({rd_pe, rd_fe, rd_brk} !== 3'b100) begin errors++; $display("FAIL even_flags pe/fe/brk: got %b want 100", {rd_pe, rd_fe, rd_brk}); end
    pop_one();
    parity = 3'd2; stop2 = 1'b1;
    send_frame(8'h15, 5, 0, 2);
    checks++; if (rd_data !== 8'h15 || rd_pe !== 1'b0 || rd_fe !== 1'b0) begin errors++; $display("FAIL odd_ok: got %h pe=%b fe=%b want 15/0/0", rd_data, rd_pe, rd_fe); end
    pop_one();
  endtask

  task automatic test_framing();
    size = 2'd3; parity = 3'd0; stop2 = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i == 0 || i == 7);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    checks++; if ({rd_data, rd_fe, rd_pe, rd_brk} !== {8'h81, 3'b100}) begin errors++; $display("FAIL framing: got %h fe=%b pe=%b brk=%b want 81/1/0/0", rd_data, rd_fe, rd_pe, rd_brk); end
    pop_one();
  endtask

  task automatic test_glitch();
    in_line = 1'b0; do_ticks(6);
    in_line = 1'b1; do_ticks(2 * OS);
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL glitch_state: got %0d want IDLE", dut.state_q); end
    checks++; if (level !== '0 || empty !== 1'b1) begin errors++; $display("FAIL glitch_level: got %0d want 0", level); end
    pop_one();
    checks++; if (level !== '0 || empty !== 1'b1) begin errors++; $display("FAIL empty_read: level=%0d empty=%b want 0/1", level, empty); end
  endtask

  task automatic test_overrun();
    size = 2'd3; parity = 3'd0; stop2 = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, -1, 1);
    checks++; if (full !== 1'b1 || level !== LW'(DEPTH)) begin errors++; $display("FAIL ovr_full: full=%b level=%0d want 1/4", full, level); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL ovr_pop%0d: got %h want %h", i, rd_data, 8'(i)); end
      pop_one();
    end
    checks++; if (empty !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_drain: empty=%b overrun=%b want 1/1", empty, overrun); end
    @(negedge clk); clear_overrun = 1'b1;
    @(negedge clk); clear_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_break();
    size = 2'd3; parity = 3'd2; stop2 = 1'b0;
    in_line = 1'b0; do_ticks(12 * OS);
    checks++; if (level !== LW'(1)) begin errors++; $display("FAIL brk_level: got %0d want 1", level); end
    checks++; if ({rd_brk, rd_fe, rd_data} !== {2'b11, 8'h00}) begin errors++; $display("FAIL brk_entry: brk=%b fe=%b data=%h want 1/1/00", rd_brk, rd_fe, rd_data); end
    checks++; if (dut.state_q !== S_BRKWAIT) begin errors++; $display("FAIL brk_wait: got %0d want BRKWAIT", dut.state_q); end
    in_line = 1'b1; do_ticks(2 * OS);
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL brk_exit: got %0d want IDLE", dut.state_q); end
    // 0x3C has four ones, so odd parity wants a 1 on the wire.
    send_frame(8'h3C, 8, 1, 1);
    pop_one();
    checks++; if ({rd_data, rd_fe, rd_pe, rd_brk} !== {8'h3C, 3'b000}) begin errors++; $display("FAIL brk_next: got %h fe=%b pe=%b brk=%b want 3c/0/0/0", rd_data, rd_fe, rd_pe, rd_brk); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    size = 2'd3; parity = 3'd0; stop2 = 1'b0;
    send_frame(8'h11, 8, -1, 1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); in_line = 1'b1; do_ticks(5);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (level !== '0 || empty !== 1'b1 || dut.state_q !== S_IDLE) begin errors++; $display("FAIL mid_reset: level=%0d empty=%b state=%0d want 0/1/IDLE", level, empty, dut.state_q); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_ticks(2 * OS);
    send_frame(8'h7E, 8, -1, 1);
    checks++; if (level !== LW'(1) || rd_data !== 8'h7E) begin errors++; $display("FAIL mid_after: level=%0d data=%h want 1/7e", level, rd_data); end
  endtask

  task automatic test_enable();
    // FIFO still holds 0x7E; a frame cut short by enable=0 must not disturb it.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk); enable = 1'b0;
    do_ticks(4);
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL en_state: got %0d want IDLE", dut.state_q); end
    in_line = 1'b1; do_ticks(2);
    enable = 1'b1; do_ticks(3 * OS);
    checks++; if (level !== LW'(1) || rd_data !== 8'h7E) begin errors++; $display("FAIL en_keep: level=%0d data=%h want 1/7e", level, rd_data); end
    pop_one();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL en_read: empty=%b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_overrun();
    test_break();
    test_reset_mid();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
